stripe_lane_ctrl: RTL

- Sequencing controller for the two-lane byte-striping datapath.
- Accepts a 32-bit word stream on clk_2f with a valid/ready handshake and distributes words strictly alternating lane 0, lane 1, lane 0, …
- Each lane has its own registered output with per-lane valid/ready backpressure.
- Frames each burst: a SYNC word on both lanes at burst start, a PAD word on lane 1 at burst end when the word count is odd, and a return to IDLE (pointer back to lane 0) after an input gap.

---
 rtl/stripe_lane_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stripe_lane_ctrl.sv
// Two-lane striping sequencer: alternates accepted words across lane 0/1,
// frames each burst with SYNC on both lanes and balances odd bursts with PAD.
module stripe_lane_ctrl #(
  parameter int unsigned IDLE_GAP  = 4,
  parameter logic [31:0] SYNC_WORD = 32'h0000_00BC,
  parameter logic [31:0] PAD_WORD  = 32'h0000_007C
) (
  input  logic        clk_2f,
  input  logic        reset_L,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  output logic        in_rdy,
  input  logic        lane_rdy_0,
  input  logic        lane_rdy_1,
  output logic        valid_0,
  output logic [31:0] lane_0,
  output logic        valid_1,
  output logic [31:0] lane_1,
  output logic        lane_ptr,
  output logic [1:0]  state,
  output logic [15:0] word_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ALIGN  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_PAD    = 2'd3;

  localparam int unsigned       GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             v0_q, v0_d, v1_q, v1_d;
  logic [31:0]      l0_q, l0_d, l1_q, l1_d;

  logic free_0, free_1, xfer;

  // A lane register is free if empty or being drained on this edge.
  assign free_0 = ~v0_q | lane_rdy_0;
  assign free_1 = ~v1_q | lane_rdy_1;
  assign in_rdy = (state_q == S_ACTIVE) && (ptr_q ? free_1 : free_0);
  assign xfer   = valid_in & in_rdy;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    v0_d    = v0_q & ~lane_rdy_0;
    v1_d    = v1_q & ~lane_rdy_1;
    l0_d    = l0_q;
    l1_d    = l1_q;
    case (state_q)
      S_IDLE: begin
        ptr_d = 1'b0;
        gap_d = '0;
        if (valid_in) state_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (free_0 && free_1) begin
          v0_d    = 1'b1;
          v1_d    = 1'b1;
          l0_d    = SYNC_WORD;
          l1_d    = SYNC_WORD;
          ptr_d   = 1'b0;
          gap_d   = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          if (ptr_q) begin
            v1_d = 1'b1;
            l1_d = data_in;
          end else begin
            v0_d = 1'b1;
            l0_d = data_in;
          end
          ptr_d = ~ptr_q;
          cnt_d = cnt_q + 16'd1;
          gap_d = '0;
        end else if (valid_in) begin
          // Stalled by a busy lane: pending input keeps the burst open.
          gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ptr_q ? S_PAD : S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_PAD: begin
        if (free_1) begin
          v1_d    = 1'b1;
          l1_d    = PAD_WORD;
          ptr_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gap_q   <= '0;
      cnt_q   <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      l0_q    <= '0;
      l1_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      l0_q    <= l0_d;
      l1_q    <= l1_d;
    end
  end

  assign valid_0  = v0_q;
  assign lane_0   = l0_q;
  assign valid_1  = v1_q;
  assign lane_1   = l1_q;
  assign lane_ptr = ptr_q;
  assign state    = state_q;
  assign word_cnt = cnt_q;

endmodule
